// File: rtl/sb_reg_access_arbiter.sv
// sb_reg_access_arbiter: round-robin arbiter and sequencer for the 157-byte
// sideband register file. Two requesters (A: AT-command handler, B: lane-init
// FSM) each issue a read or a 1-3 byte write. Writes are split into one
// s_write cycle per byte with an incrementing address. Reads are one s_read
// pulse, and the masked sb_read word comes back after READ_LAT cycles.
//
// Handshake: x_req is level-held by the requester until x_gnt. x_gnt is a
// one-cycle pulse in the IDLE cycle where the request is latched; from then on
// the requester inputs are ignored. x_done (and x_err for a rejected access)
// pulses for one cycle when the access completes, and rdata is valid with
// x_done on a read. A request still high after done is treated as a new one.
module sb_reg_access_arbiter #(
  parameter int MAX_ADDR = 156,
  parameter int READ_LAT = 1
) (
  input  logic        fsm_clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_wr,
  input  logic [7:0]  a_addr,
  input  logic [1:0]  a_len,
  input  logic [23:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_wr,
  input  logic [7:0]  b_addr,
  input  logic [1:0]  b_len,
  input  logic [23:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [23:0] rdata,
  output logic        s_read,
  output logic        s_write,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  input  logic [23:0] sb_read,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

  localparam logic [8:0] MAX_ADDR_9 = 9'(MAX_ADDR);
  localparam logic [1:0] LAT_LAST   = 2'(READ_LAT - 1);

  logic [2:0]  state;
  logic        owner_b;
  logic [7:0]  cur_addr;
  logic [1:0]  cur_len;
  logic [23:0] cur_wdata;
  logic [1:0]  byte_idx;
  logic [1:0]  lat_cnt;
  logic        prefer_b;

  logic        pick_a;
  logic        pick_b;
  logic        sel_wr;
  logic [7:0]  sel_addr;
  logic [1:0]  sel_len;
  logic [23:0] sel_wdata;
  logic [8:0]  sel_end;
  logic        sel_legal;
  logic [23:0] rd_mask;

  // Arbitration and legality of the candidate request; only active in IDLE out of reset.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (state == IDLE && rst) begin
      pick_b = b_req && (!a_req || prefer_b);
      pick_a = a_req && !pick_b;
    end
    sel_wr    = pick_b ? b_wr    : a_wr;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_len   = pick_b ? b_len   : a_len;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    // 9-bit end address so that a run past 255 cannot wrap into range.
    sel_end   = {1'b0, sel_addr} + {7'd0, sel_len} - 9'd1;
    sel_legal = (sel_len != 2'd0) && (sel_end <= MAX_ADDR_9);
  end

  // Byte-lane mask applied to the returned read word: bytes at index >= len read as 0.
  always_comb begin
    rd_mask = 24'hFFFFFF;
    case (cur_len)
      2'd1:    rd_mask = 24'h0000FF;
      2'd2:    rd_mask = 24'h00FFFF;
      default: rd_mask = 24'hFFFFFF;
    endcase
  end

  // Access sequencer: latch on grant, step write bytes / read latency, capture read data.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_b   <= 1'b0;
      cur_addr  <= 8'd0;
      cur_len   <= 2'd0;
      cur_wdata <= 24'd0;
      byte_idx  <= 2'd0;
      lat_cnt   <= 2'd0;
      prefer_b  <= 1'b0;
      rdata     <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_a || pick_b) begin
            owner_b   <= pick_b;
            prefer_b  <= pick_a;
            cur_addr  <= sel_addr;
            cur_len   <= sel_len;
            cur_wdata <= sel_wdata;
            byte_idx  <= 2'd0;
            lat_cnt   <= 2'd0;
            if (!sel_legal)  state <= ERR;
            else if (sel_wr) state <= WRITE;
            else             state <= RD_REQ;
          end
        end
        WRITE: begin
          if (byte_idx == cur_len - 2'd1) begin
            rdata <= 24'd0;
            state <= DONE;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rdata <= sb_read & rd_mask;
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes, grant and completion pulses decoded from the current state.
  always_comb begin
    a_gnt     = pick_a;
    b_gnt     = pick_b;
    a_done    = 1'b0;
    b_done    = 1'b0;
    a_err     = 1'b0;
    b_err     = 1'b0;
    s_read    = 1'b0;
    s_write   = 1'b0;
    s_address = 8'd0;
    s_data    = 8'd0;
    case (state)
      WRITE: begin
        s_write   = 1'b1;
        s_address = cur_addr + {6'd0, byte_idx};
        s_data    = 8'(cur_wdata >> {byte_idx, 3'b000});
      end
      RD_REQ: begin
        s_read    = 1'b1;
        s_address = cur_addr;
      end
      DONE: begin
        a_done = !owner_b;
        b_done = owner_b;
      end
      ERR: begin
        a_done = !owner_b;
        b_done = owner_b;
        a_err  = !owner_b;
        b_err  = owner_b;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_sb_reg_access_arbiter.sv
// Bench for sb_reg_access_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_sb_reg_access_arbiter;

  localparam int MAX_ADDR = 156;
  localparam int LAT      = 1;

  // ---------------- clock / reset ----------------
  logic fsm_clk = 1'b0;
  logic rst     = 1'b0;
  int   cyc     = 0;
  always #5 fsm_clk = ~fsm_clk;
  always @(posedge fsm_clk) cyc <= cyc + 1;

  // ---------------- main DUT (READ_LAT = 1) ----------------
  logic        a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
  logic [7:0]  a_addr = 0, b_addr = 0;
  logic [1:0]  a_len = 0, b_len = 0;
  logic [23:0] a_wdata = 0, b_wdata = 0, sb_read = 0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [23:0] rdata;
  logic        s_read, s_write;
  logic [7:0]  s_address, s_data;
  logic [2:0]  dbg_state;

  sb_reg_access_arbiter #(.MAX_ADDR(MAX_ADDR), .READ_LAT(LAT)) dut (
    .fsm_clk(fsm_clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_len(a_len), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_len(b_len), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err),
    .rdata(rdata), .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_data(s_data), .sb_read(sb_read), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (READ_LAT = 3) ----------------
  logic        l3_a_req = 0, l3_a_wr = 0;
  logic [7:0]  l3_a_addr = 0;
  logic [1:0]  l3_a_len = 0;
  logic [23:0] l3_a_wdata = 0, l3_sb_read = 0;
  logic        l3_b_req = 0, l3_b_wr = 0;
  logic [7:0]  l3_b_addr = 0;
  logic [1:0]  l3_b_len = 0;
  logic [23:0] l3_b_wdata = 0;
  logic        l3_a_gnt, l3_a_done, l3_a_err, l3_b_gnt, l3_b_done, l3_b_err;
  logic [23:0] l3_rdata;
  logic        l3_s_read, l3_s_write;
  logic [7:0]  l3_s_address, l3_s_data;
  logic [2:0]  l3_dbg_state;

  sb_reg_access_arbiter #(.MAX_ADDR(MAX_ADDR), .READ_LAT(3)) dut_l3 (
    .fsm_clk(fsm_clk), .rst(rst),
    .a_req(l3_a_req), .a_wr(l3_a_wr), .a_addr(l3_a_addr), .a_len(l3_a_len), .a_wdata(l3_a_wdata),
    .a_gnt(l3_a_gnt), .a_done(l3_a_done), .a_err(l3_a_err),
    .b_req(l3_b_req), .b_wr(l3_b_wr), .b_addr(l3_b_addr), .b_len(l3_b_len), .b_wdata(l3_b_wdata),
    .b_gnt(l3_b_gnt), .b_done(l3_b_done), .b_err(l3_b_err),
    .rdata(l3_rdata), .s_read(l3_s_read), .s_write(l3_s_write), .s_address(l3_s_address),
    .s_data(l3_s_data), .sb_read(l3_sb_read), .dbg_state(l3_dbg_state)
  );

  // ---------------- scoreboard counters and logs ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] wlog[$];   // {address, data} of each observed write strobe
  logic [7:0]  rlog[$];   // address of each observed read strobe
  logic        glog[$];   // grant order: 0 = A, 1 = B
  int   a_done_cnt = 0;
  int   l3_srd_cnt = 0;
  logic [7:0] l3_srd_addr = 0;
  logic a_gseen = 0, b_gseen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] len_mask(input logic [1:0] l);
    logic [31:0] m;
    m = (32'd1 << (8 * int'(l))) - 32'd1;
    return m[23:0];
  endfunction

  // ---------------- timeline model ----------------
  // A granted access occupies cycles g+1 .. g+D where D is the done offset
  // (len+1 for a write, LAT+2 for a read, 1 for a rejected access); the
  // arbiter can grant again from g+D+1.
  logic        m_act = 0, m_owner_b = 0, m_wr = 0, m_err = 0, m_pref_b = 0;
  logic [7:0]  m_addr = 0;
  logic [1:0]  m_len = 0;
  logic [23:0] m_wdata = 0, m_rdata = 0, m_cap = 0;
  int          m_g = 0, m_d = 0, m_free = 0;

  always @(negedge fsm_clk) begin : mon
    logic e_ag, e_bg, e_ad, e_bd, e_ae, e_be, e_sr, e_sw, pb;
    logic [7:0] e_sa, e_sd;
    int t;
    e_ag = 0; e_bg = 0; e_ad = 0; e_bd = 0; e_ae = 0; e_be = 0; e_sr = 0; e_sw = 0;
    e_sa = 0; e_sd = 0; pb = 0; t = 0;
    if (!rst) begin
      m_act = 0; m_pref_b = 0; m_free = 0; m_rdata = 0;
    end else begin
      if (m_act) begin
        t = cyc - m_g;
        if (m_err) begin
          if (t == 1) begin e_ad = !m_owner_b; e_bd = m_owner_b; e_ae = !m_owner_b; e_be = m_owner_b; end
        end else if (m_wr) begin
          if (t >= 1 && t <= int'(m_len)) begin
            e_sw = 1; e_sa = m_addr + 8'(t - 1); e_sd = m_wdata[8*(t-1) +: 8];
          end
          if (t == m_d) m_rdata = 24'd0;
        end else begin
          if (t == 1) begin e_sr = 1; e_sa = m_addr; end
          if (t == m_d - 1) m_cap = sb_read & len_mask(m_len);
          if (t == m_d) m_rdata = m_cap;
        end
        if (t == m_d) begin
          e_ad = !m_owner_b; e_bd = m_owner_b; m_act = 0;
        end
      end
      if (cyc >= m_free && (a_req || b_req)) begin
        pb = b_req && (!a_req || m_pref_b);
        e_ag = !pb; e_bg = pb;
        m_owner_b = pb;
        m_wr    = pb ? b_wr : a_wr;
        m_addr  = pb ? b_addr : a_addr;
        m_len   = pb ? b_len : a_len;
        m_wdata = pb ? b_wdata : a_wdata;
        m_err   = (m_len == 0) || (int'(m_addr) + int'(m_len) - 1 > MAX_ADDR);
        m_d     = m_err ? 1 : (m_wr ? int'(m_len) + 1 : LAT + 2);
        m_g     = cyc;
        m_free  = cyc + m_d + 1;
        m_pref_b = !pb;
        m_act   = 1;
      end
    end
    chk("a_gnt", a_gnt, e_ag);
    chk("b_gnt", b_gnt, e_bg);
    chk("a_done", a_done, e_ad);
    chk("b_done", b_done, e_bd);
    chk("a_err", a_err, e_ae);
    chk("b_err", b_err, e_be);
    chk("s_read", s_read, e_sr);
    chk("s_write", s_write, e_sw);
    chk("s_address", s_address, e_sa);
    chk("s_data", s_data, e_sd);
    chk("rdata", rdata, m_rdata);
    // observation logs for the directed scenarios
    a_gseen = a_gnt;
    b_gseen = b_gnt;
    if (s_write) wlog.push_back({s_address, s_data});
    if (s_read) rlog.push_back(s_address);
    if (a_gnt) glog.push_back(1'b0);
    if (b_gnt) glog.push_back(1'b1);
    if (a_done) a_done_cnt++;
    if (l3_s_read) begin l3_srd_cnt++; l3_srd_addr = l3_s_address; end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic who_b, input logic wr, input logic [7:0] addr,
                         input logic [1:0] len, input logic [23:0] wd);
    if (who_b) begin b_req = 1; b_wr = wr; b_addr = addr; b_len = len; b_wdata = wd; end
    else       begin a_req = 1; a_wr = wr; a_addr = addr; a_len = len; a_wdata = wd; end
  endtask

  task automatic run_one(input logic who_b, input logic wr, input logic [7:0] addr,
                         input logic [1:0] len, input logic [23:0] wd,
                         output int lat, output logic err_seen, output logic [23:0] rd);
    logic got;
    int g;
    lat = -1; err_seen = 0; rd = 0; g = 0;
    wlog.delete(); rlog.delete();
    @(posedge fsm_clk); #1;
    set_req(who_b, wr, addr, len, wd);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge fsm_clk);
      if (who_b ? b_gnt : a_gnt) begin got = 1; g = cyc; end
    end
    chk("gnt_seen", got, 1);
    @(posedge fsm_clk); #1;
    if (who_b) b_req = 0; else a_req = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge fsm_clk);
      if (who_b ? b_done : a_done) begin
        got = 1; lat = cyc - g; err_seen = who_b ? b_err : a_err; rd = rdata;
      end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge fsm_clk); #1;
      if (a_req && a_gseen) a_req = 0;
      if (b_req && b_gseen) b_req = 0;
    end
  endtask

  task automatic rand_txn(output logic wr, output logic [7:0] addr,
                          output logic [1:0] len, output logic [23:0] wd);
    wr   = 1'($urandom_range(0, 1));
    addr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(150, 160)) : 8'($urandom_range(0, 255));
    len  = 2'($urandom_range(0, 3));
    wd   = 24'($urandom);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    logic er;
    logic [23:0] rd;
    logic got;
    int g, dcnt;
    logic w; logic [7:0] ad; logic [1:0] ln; logic [23:0] wd;

    // reset state
    repeat (3) @(posedge fsm_clk);
    @(negedge fsm_clk);
    chk("rst_rdata", rdata, 0);
    chk("rst_s_address", s_address, 0);
    @(posedge fsm_clk); #1;
    rst = 1;
    repeat (2) @(posedge fsm_clk);

    // write A: 78/79/80 <- 33/03/05, done 4 cycles after grant
    run_one(0, 1, 8'd78, 2'd3, 24'h050333, lat, er, rd);
    chk("wrA_lat", lat, 4);
    chk("wrA_err", er, 0);
    chk("wrA_nbytes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("wrA_b0", wlog[0], 16'h4E33);
      chk("wrA_b1", wlog[1], 16'h4F03);
      chk("wrA_b2", wlog[2], 16'h5005);
    end
    chk("wrA_rdata", rd, 0);

    // read B: addr 78 len 2, returns masked word 3 cycles after grant
    sb_read = 24'h050333;
    run_one(1, 0, 8'd78, 2'd2, 24'h0, lat, er, rd);
    chk("rdB_lat", lat, 3);
    chk("rdB_rdata", rd, 24'h000333);
    chk("rdB_nreads", rlog.size(), 1);
    if (rlog.size() == 1) chk("rdB_addr", rlog[0], 8'd78);

    // legality boundaries
    run_one(0, 1, 8'd155, 2'd3, 24'h123456, lat, er, rd);
    chk("err_end_lat", lat, 1);
    chk("err_end_flag", er, 1);
    chk("err_end_strobes", wlog.size() + rlog.size(), 0);
    chk("err_end_rdata", rd, 24'h000333);
    run_one(0, 1, 8'd10, 2'd0, 24'h123456, lat, er, rd);
    chk("err_len0_lat", lat, 1);
    chk("err_len0_flag", er, 1);
    run_one(0, 1, 8'd154, 2'd3, 24'hA1B2C3, lat, er, rd);
    chk("legal154_lat", lat, 4);
    chk("legal154_flag", er, 0);
    if (wlog.size() == 3) chk("legal154_last", wlog[2], 16'h9CA1);
    else chk("legal154_nbytes", wlog.size(), 3);

    // ties from reset alternate A, B, A, B
    @(posedge fsm_clk); #1;
    rst = 0;
    set_req(0, 1, 8'd20, 2'd1, 24'h11);
    set_req(1, 1, 8'd21, 2'd1, 24'h22);
    @(posedge fsm_clk); #1;
    glog.delete();
    rst = 1;
    repeat (14) @(posedge fsm_clk);
    #1;
    a_req = 0; b_req = 0;
    chk("tie_count_ge4", glog.size() >= 4, 1);
    if (glog.size() >= 4) begin
      chk("tie0", glog[0], 0);
      chk("tie1", glog[1], 1);
      chk("tie2", glog[2], 0);
      chk("tie3", glog[3], 1);
    end
    repeat (6) @(posedge fsm_clk);

    // reset in the middle of a 3-byte write
    wlog.delete();
    @(posedge fsm_clk); #1;
    set_req(0, 1, 8'd10, 2'd3, 24'h112233);
    got = 0; g = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge fsm_clk);
      if (a_gnt) begin got = 1; g = cyc; end
    end
    chk("rstmid_gnt", got, 1);
    dcnt = a_done_cnt;
    @(posedge fsm_clk); #1; a_req = 0;
    @(posedge fsm_clk); #1;
    @(posedge fsm_clk); #1;
    rst = 0;
    set_req(0, 1, 8'd30, 2'd1, 24'h44);
    set_req(1, 1, 8'd31, 2'd1, 24'h55);
    @(negedge fsm_clk);
    chk("rstmid_s_write", s_write, 0);
    chk("rstmid_s_address", s_address, 0);
    @(posedge fsm_clk); #1;
    @(posedge fsm_clk); #1;
    chk("rstmid_no_done", a_done_cnt - dcnt, 0);
    chk("rstmid_nbytes", wlog.size(), 2);
    if (wlog.size() >= 2) chk("rstmid_b1", wlog[1], 16'h0B22);
    rst = 1;
    @(negedge fsm_clk);
    chk("rstmid_tie_a", a_gnt, 1);
    chk("rstmid_tie_b", b_gnt, 0);
    drain(15);

    // READ_LAT = 3 instance: read 85 len 1, done 5 cycles after grant
    l3_srd_cnt = 0;
    @(posedge fsm_clk); #1;
    l3_sb_read = 24'hAABBCC;
    l3_a_req = 1; l3_a_wr = 0; l3_a_addr = 8'd85; l3_a_len = 2'd1;
    got = 0; g = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge fsm_clk);
      if (l3_a_gnt) begin got = 1; g = cyc; end
    end
    chk("l3_gnt", got, 1);
    @(posedge fsm_clk); #1; l3_a_req = 0;
    got = 0; lat = -1; rd = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge fsm_clk);
      if (l3_a_done) begin got = 1; lat = cyc - g; rd = l3_rdata; end
    end
    chk("l3_done", got, 1);
    chk("l3_lat", lat, 5);
    chk("l3_rdata", rd, 24'h0000CC);
    chk("l3_nreads", l3_srd_cnt, 1);
    chk("l3_raddr", l3_srd_addr, 8'd85);

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      @(posedge fsm_clk); #1;
      sb_read = 24'($urandom);
      if ($urandom_range(0, 699) == 0) rst = 0;
      else rst = 1;
      if (a_req && a_gseen) begin
        if ($urandom_range(0, 1) == 0) a_req = 0;
        else begin rand_txn(w, ad, ln, wd); set_req(0, w, ad, ln, wd); end
      end else if (!a_req && $urandom_range(0, 3) == 0) begin
        rand_txn(w, ad, ln, wd); set_req(0, w, ad, ln, wd);
      end
      if (b_req && b_gseen) begin
        if ($urandom_range(0, 1) == 0) b_req = 0;
        else begin rand_txn(w, ad, ln, wd); set_req(1, w, ad, ln, wd); end
      end else if (!b_req && $urandom_range(0, 3) == 0) begin
        rand_txn(w, ad, ln, wd); set_req(1, w, ad, ln, wd);
      end
    end
    @(posedge fsm_clk); #1;
    rst = 1;
    drain(20);
    repeat (3) @(posedge fsm_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sb_reg_access_arbiter.md
Name: sb_reg_access_arbiter

Overview:
- Arbitrates and sequences accesses to the 157-byte sideband register file on behalf of two requesters: A (sideband AT-command handler) and B (local lane-init FSM).
- Each requester issues a read or a 1–3 byte write. The block serialises writes into per-byte s_write cycles with an incrementing s_address.
- Reads are a single s_read pulse; the returned sb_read word is handed back after a fixed latency.
- Sits between the sideband control logic and the register file, and is the only driver of the register-file strobes.

Parameters:
- MAX_ADDR, 156, highest valid register-file byte address.
- READ_LAT, 1, cycles from the s_read pulse to valid sb_read (1..3).

Ports:
- fsm_clk input 1: single block clock.
- rst input 1: asynchronous, active-low reset.
- a_req input 1: requester A access request, level-held until a_gnt.
- a_wr input 1: A access type, 1 = write, 0 = read.
- a_addr input 8: A start byte address.
- a_len input 2: A byte count, 1..3; 0 is illegal.
- a_wdata input 24: A write data; byte0 = [7:0].
- a_gnt output 1: one-cycle pulse, A request accepted and latched.
- a_done output 1: one-cycle pulse, A access complete.
- a_err output 1: one-cycle pulse with a_done, A access rejected.
- b_req, b_wr, b_addr, b_len, b_wdata, b_gnt, b_done, b_err: requester B, identical to the A ports.
- rdata output 24: read data, valid while a_done or b_done is high on a read.
- s_read output 1: register-file read strobe.
- s_write output 1: register-file write strobe.
- s_address output 8: register-file byte address.
- s_data output 8: register-file write byte.
- sb_read input 24: register-file read word.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE and the round-robin pointer favours A.
  - All outputs go to 0, including rdata, strobes, address and data.
- States: IDLE, WRITE, RD_REQ, RD_WAIT, DONE, ERR.
- IDLE arbitration:
  - If only one req is high, grant it.
  - If both are high, grant the requester not granted last. After reset, A wins a tie.
  - On grant, pulse x_gnt for one cycle and latch wr/addr/len/wdata plus the owner ID. Requester inputs are ignored after the latch.
- Legality check on the latched values:
  - Illegal if len == 0.
  - Illegal if addr + len - 1 > MAX_ADDR, computed at 9-bit width with no wrap.
  - Illegal → ERR. Legal write → WRITE. Legal read → RD_REQ.
- WRITE lasts len cycles. On byte i (0..len-1): s_write=1, s_address=addr+i, s_data=wdata[8i+7:8i]. After the last byte go to DONE.
- RD_REQ lasts one cycle: s_read=1, s_address=addr. Then go to RD_WAIT.
- RD_WAIT lasts READ_LAT cycles. In its final cycle, capture sb_read into rdata with bytes at index ≥ len zeroed. Then go to DONE.
- DONE lasts one cycle: pulse owner x_done. rdata holds its captured value (0 for writes) until the next capture or reset. Return to IDLE.
- ERR lasts one cycle: pulse owner x_done and x_err, with no strobe and rdata unchanged. Return to IDLE.
- Strobe rules:
  - s_read and s_write are never high in the same cycle.
  - Strobes are never high in IDLE, DONE or ERR.
  - s_address/s_data return to 0 when no strobe is high.
- Latency from grant cycle to done pulse:
  - Write: len+1 cycles.
  - Read: READ_LAT+2 cycles.
  - Error: 1 cycle.
- Back-to-back: a req still high in IDLE after done is a new request. Minimum one IDLE cycle between accesses.
- Non-owner req is held pending, never dropped. The round-robin pointer updates at grant.
- Reset mid-access aborts immediately: no done pulse and no further strobes. A partially written multi-byte access stays partial.

Test Plan:
- Write A: a_wr=1, addr=78, len=3, wdata=0x050333 → s_write for 3 cycles at 78/79/80 with data 0x33/0x03/0x05; a_done 4 cycles after a_gnt; a_err=0.
- Read B: b_wr=0, addr=78, len=2, sb_read=0x050333, READ_LAT=1 → single s_read at 78; b_done 3 cycles after b_gnt; rdata=0x000333.
- Simultaneous requests from reset: both req high, both write len=1 → A granted first, B granted next; on the next tie A is granted again, alternating with B.
- Error check: addr=155, len=3 → a_gnt then a_done and a_err in the following cycle; no strobes. Repeat with len=0 → same response. Repeat with addr=154, len=3 → legal.
- Reset mid-write: deassert rst after byte 1 of a len=3 write → outputs 0 immediately, no a_done; after reset release, a tie is granted to A.
- READ_LAT=3 build: read addr=85, len=1, sb_read=0xAABBCC → rdata=0x0000CC; done 5 cycles after grant; s_read high for exactly 1 cycle.
